// File: rtl/priority_decoder_pipe.sv
// priority_decoder_pipe
//   Two-entry skid FIFO that carries encoder codes {en, idx[2:0]} and presents
//   the head entry decoded to a one-hot byte. Every popped word is ORed into a
//   sticky hit mask and counted in a wrapping 8-bit transfer counter.
//
//   state   | meaning
//   --------+-------------------------------------------
//   S_EMPTY | no entries held, out_valid = 0
//   S_ONE   | one entry held at r_rptr
//   S_TWO   | both entries held, in_ready = 0
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : upstream code word valid
//   in_ready   : block accepts a code word this cycle (state-derived only)
//   in_idx     : 3-bit encoder index
//   in_en      : encoder valid flag (0 = no bit was set)
//   out_valid  : out_onehot holds a decoded word
//   out_ready  : downstream accepts the word
//   out_onehot : decoded head word
//   clr        : synchronous clear of hit_mask and xfer_cnt
//   hit_mask   : sticky OR of all popped one-hot words
//   xfer_cnt   : count of popped words, wraps at 256
module priority_decoder_pipe #(
  parameter int DEPTH = 2  // only 2 is supported: pointers are 1 bit wide
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_idx,
  input  logic       in_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_onehot,
  input  logic       clr,
  output logic [7:0] hit_mask,
  output logic [7:0] xfer_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  occ_t       r_state;
  occ_t       w_state_nxt;
  logic [3:0] r_mem [DEPTH];
  logic       r_wptr;
  logic       r_rptr;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [7:0] r_hit_mask;
  logic [7:0] r_xfer_cnt;

  logic       w_push;
  logic       w_pop;
  logic [3:0] w_head;
  logic [7:0] w_onehot;
  logic [7:0] w_hit_base;
  logic [7:0] w_cnt_base;

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  assign w_head   = r_mem[r_rptr];
  assign w_onehot = (r_out_valid && w_head[3]) ? (8'h01 << w_head[2:0]) : 8'h00;

  // Clear is applied before a coincident pop accumulates.
  assign w_hit_base = clr ? 8'h00 : r_hit_mask;
  assign w_cnt_base = clr ? 8'h00 : r_xfer_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_push) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = S_TWO;
        else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
      end
      S_TWO:   if (w_pop) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_hit_mask  <= 8'h00;
      r_xfer_cnt  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 4'h0;
    end else begin
      r_state     <= w_state_nxt;
      // Handshake flags are registered from the next state, so in_ready has
      // no combinational path from out_ready.
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_push) begin
        r_mem[r_wptr] <= {in_en, in_idx};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr     <= ~r_rptr;
        r_hit_mask <= w_hit_base | w_onehot;
        r_xfer_cnt <= w_cnt_base + 8'd1;
      end else if (clr) begin
        r_hit_mask <= 8'h00;
        r_xfer_cnt <= 8'h00;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_onehot = w_onehot;
  assign hit_mask   = r_hit_mask;
  assign xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_priority_decoder_pipe.sv
// tb_priority_decoder_pipe
//   Drives priority_decoder_pipe on the falling edge and compares its outputs
//   against a queue-based reference model and against fixed expected values.
module tb_priority_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
  logic       clr;
  logic [7:0] hit_mask;
  logic [7:0] xfer_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [3:0] mq[$];
  logic [7:0] m_hit = 8'h00;
  logic [7:0] m_cnt = 8'h00;

  always #5 clk = ~clk;

  priority_decoder_pipe #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_onehot(out_onehot),
    .clr       (clr),
    .hit_mask  (hit_mask),
    .xfer_cnt  (xfer_cnt)
  );

  function automatic logic [7:0] exp_onehot();
    logic [3:0] h;
    if (mq.size() == 0) return 8'h00;
    h = mq[0];
    if (!h[3]) return 8'h00;
    return 8'(2 ** int'(h[2:0]));
  endfunction

  // Applies one cycle of inputs (called just after a falling edge), advances
  // the model across the rising edge and returns at the next falling edge.
  task automatic drive_cycle(input logic iv, input logic [2:0] idx, input logic en,
                             input logic ordy, input logic c);
    logic       do_push;
    logic       do_pop;
    logic [7:0] oh;
    logic [3:0] dropped;
    in_valid  = iv;
    in_idx    = idx;
    in_en     = en;
    out_ready = ordy;
    clr       = c;
    do_push = iv && (mq.size() < 2);
    do_pop  = ordy && (mq.size() != 0);
    oh = exp_onehot();
    @(posedge clk);
    if (do_pop) begin
      dropped = mq.pop_front();
      m_hit = (c ? 8'h00 : m_hit) | oh;
      m_cnt = (c ? 8'h00 : m_cnt) + 8'd1;
    end else if (c) begin
      m_hit = 8'h00;
      m_cnt = 8'h00;
    end
    if (do_push) mq.push_back({en, idx});
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_idx = 3'd0; in_en = 1'b0;
    out_ready = 1'b0; clr = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_onehot !== 8'h00) begin failures++; $display("FAIL reset_onehot got=%h exp=00", out_onehot); end
    checks++; if (hit_mask !== 8'h00) begin failures++; $display("FAIL reset_hit got=%h exp=00", hit_mask); end
    checks++; if (xfer_cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", xfer_cnt); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_onehot !== 8'h20) begin failures++; $display("FAIL single_onehot got=%h exp=20", out_onehot); end
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (hit_mask !== 8'h20) begin failures++; $display("FAIL single_hit got=%h exp=20", hit_mask); end
    checks++; if (xfer_cnt !== 8'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", xfer_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    drive_cycle(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    checks++; if (out_onehot !== 8'h04) begin failures++; $display("FAIL bp_head got=%h exp=04", out_onehot); end
    drive_cycle(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);  // rejected, head must hold
    checks++; if (out_onehot !== 8'h04) begin failures++; $display("FAIL bp_stable got=%h exp=04", out_onehot); end
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (out_onehot !== 8'h80) begin failures++; $display("FAIL bp_second got=%h exp=80", out_onehot); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got=%b exp=1", in_ready); end
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    checks++; if (hit_mask !== 8'hA4) begin failures++; $display("FAIL bp_hit got=%h exp=a4", hit_mask); end
    checks++; if (xfer_cnt !== 8'd3) begin failures++; $display("FAIL bp_cnt got=%0d exp=3", xfer_cnt); end
  endtask

  task automatic test_en_zero();
    drive_cycle(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL enz_valid got=%b exp=1", out_valid); end
    checks++; if (out_onehot !== 8'h00) begin failures++; $display("FAIL enz_onehot got=%h exp=00", out_onehot); end
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (xfer_cnt !== 8'd4) begin failures++; $display("FAIL enz_cnt got=%0d exp=4", xfer_cnt); end
    checks++; if (hit_mask !== 8'hA4) begin failures++; $display("FAIL enz_hit got=%h exp=a4", hit_mask); end
  endtask

  task automatic test_simul();
    drive_cycle(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sim_valid got=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sim_ready got=%b exp=1", in_ready); end
    checks++; if (out_onehot !== 8'h02) begin failures++; $display("FAIL sim_head got=%h exp=02", out_onehot); end
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sim_occ1 got=%b exp=0", out_valid); end
    checks++; if (hit_mask !== 8'hE6) begin failures++; $display("FAIL sim_hit got=%h exp=e6", hit_mask); end
    checks++; if (xfer_cnt !== 8'd6) begin failures++; $display("FAIL sim_cnt got=%0d exp=6", xfer_cnt); end
  endtask

  task automatic test_wrap_clr();
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (hit_mask !== 8'h00) begin failures++; $display("FAIL clr_hit got=%h exp=00", hit_mask); end
    checks++; if (xfer_cnt !== 8'h00) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", xfer_cnt); end
    drive_cycle(1'b1, 3'($urandom_range(7)), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 254; i++)
      drive_cycle(1'b1, 3'($urandom_range(7)), 1'($urandom_range(1)), 1'b1, 1'b0);
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (xfer_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", xfer_cnt); end
    checks++; if (hit_mask !== m_hit) begin failures++; $display("FAIL wrap_hit got=%h exp=%h", hit_mask, m_hit); end
    drive_cycle(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (xfer_cnt !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d exp=0", xfer_cnt); end
    drive_cycle(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (hit_mask !== 8'h01) begin failures++; $display("FAIL clrpop_hit got=%h exp=01", hit_mask); end
    checks++; if (xfer_cnt !== 8'd1) begin failures++; $display("FAIL clrpop_cnt got=%0d exp=1", xfer_cnt); end
  endtask

  task automatic test_async_rst();
    drive_cycle(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_full got=%b exp=0", in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
    checks++; if (hit_mask !== 8'h00) begin failures++; $display("FAIL arst_hit got=%h exp=00", hit_mask); end
    checks++; if (xfer_cnt !== 8'h00) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", xfer_cnt); end
    checks++; if (out_onehot !== 8'h00) begin failures++; $display("FAIL arst_onehot got=%h exp=00", out_onehot); end
    mq.delete();
    m_hit = 8'h00;
    m_cnt = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    checks++; if (out_onehot !== 8'h80) begin failures++; $display("FAIL arst_first got=%h exp=80", out_onehot); end
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (xfer_cnt !== 8'd1) begin failures++; $display("FAIL arst_cnt1 got=%0d exp=1", xfer_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] eoh;
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(3) != 0),
                  1'($urandom_range(1)), 1'($urandom_range(7) == 0));
      eoh = exp_onehot();
      checks++; if (in_ready !== (mq.size() < 2)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, mq.size() < 2); end
      checks++; if (out_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, mq.size() != 0); end
      checks++; if (out_onehot !== eoh) begin failures++; $display("FAIL rnd_onehot cyc=%0d got=%h exp=%h", i, out_onehot, eoh); end
      checks++; if (hit_mask !== m_hit) begin failures++; $display("FAIL rnd_hit cyc=%0d got=%h exp=%h", i, hit_mask, m_hit); end
      checks++; if (xfer_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, xfer_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_en_zero();
    test_simul();
    test_wrap_clr();
    test_async_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_decoder_pipe.md
PRIORITY_DECODER_PIPE -- requirements
Module: priority_decoder_pipe

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning skid-buffer entries; only the value 2 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream code word is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a code word this cycle.
REQ-006 The block SHALL have port in_idx, input, 3 bits: encoded index, the 3-bit encoder code.
REQ-007 The block SHALL have port in_en, input, 1 bit: the encoder valid flag; 0 means no bit was set.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_onehot holds a decoded word.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-010 The block SHALL have port out_onehot, output, 8 bits: decoded one-hot word.
REQ-011 The block SHALL have port clr, input, 1 bit: synchronous clear of hit_mask and xfer_cnt.
REQ-012 The block SHALL have port hit_mask, output, 8 bits: sticky OR of all popped one-hot words.
REQ-013 The block SHALL have port xfer_cnt, output, 8 bits: count of popped words.

Function
REQ-014 The block SHALL perform a push when in_valid && in_ready, storing {in_en, in_idx} at the FIFO tail.
REQ-015 The block SHALL perform a pop when out_valid && out_ready, removing the head entry.
REQ-016 in_ready SHALL be 1 exactly when occupancy < 2; in_ready SHALL be registered-state-derived only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly when occupancy != 0.
REQ-018 out_onehot SHALL equal (1 << head.idx) when head.en = 1, and 8'h00 when head.en = 0 or occupancy = 0.
REQ-019 Latency SHALL be 1 cycle: a word pushed at edge N SHALL be visible at the outputs after edge N, with no bypass.
REQ-020 Output data SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-021 Push and pop in the same cycle with occupancy 1 SHALL leave occupancy at 1, with the new word at the head next cycle.
REQ-022 When occupancy is 2, a push SHALL be impossible (in_ready = 0); a pop SHALL reduce occupancy to 1.
REQ-023 Occupancy SHALL follow the states EMPTY(0) -> ONE(1) on push; ONE -> TWO on push without pop; ONE -> EMPTY on pop without push; TWO -> ONE on pop.
REQ-024 Entries SHALL pop in FIFO order; the read and write pointers SHALL be 1 bit each and wrap 1 -> 0.
REQ-025 On pop, hit_mask SHALL become hit_mask | out_onehot.
REQ-026 On pop, xfer_cnt SHALL increment by 1, and SHALL wrap 255 -> 0.
REQ-027 xfer_cnt SHALL count popped words with en = 0.
REQ-028 When clr = 1 without a pop, hit_mask and xfer_cnt SHALL become 0.
REQ-029 When clr and a pop occur together, hit_mask SHALL become out_onehot and xfer_cnt SHALL become 1, with the clear applied first.
REQ-030 clr SHALL NOT affect FIFO contents or the handshake.

Reset
REQ-031 While rst = 1, occupancy SHALL be 0, pointers 0, out_valid = 0, out_onehot = 8'h00, hit_mask = 8'h00, xfer_cnt = 8'h00, and in_ready = 1.
REQ-032 Assertion of rst mid-transfer SHALL discard all buffered words immediately, with no pop and no counter update.
REQ-033 After rst deasserts, the first push SHALL be accepted on the next rising edge.

Verification
REQ-034 The bench SHALL cover: push idx = 5, en = 1, with out_ready = 1 -> next cycle out_valid = 1 and out_onehot = 8'h20; after the pop, hit_mask = 8'h20 and xfer_cnt = 1.
REQ-035 The bench SHALL cover: out_ready = 0 with pushes idx 2 then 7 -> in_ready = 0 after the second push; then out_ready = 1 pops 8'h04 and then 8'h80 in order.
REQ-036 The bench SHALL cover: push with en = 0, idx = 3 -> out_valid = 1, out_onehot = 8'h00; after the pop, xfer_cnt increments and hit_mask is unchanged.
REQ-037 The bench SHALL cover: occupancy 1 with simultaneous push idx 1 and pop -> occupancy stays 1 and the next head is 8'h02.
REQ-038 The bench SHALL cover: xfer_cnt = 255 plus one pop -> xfer_cnt = 0; clr together with a pop of idx 0 -> hit_mask = 8'h01 and xfer_cnt = 1.
REQ-039 The bench SHALL cover: rst asserted asynchronously between edges with 2 entries held -> out_valid = 0, in_ready = 1, and hit_mask = 0, all without waiting for a clock edge.
